// File: rtl/line_access_arbiter.sv
// Shares one AXI line-transfer engine between writeback, data fill and instruction fill.
// Picks a winner, latches its request, runs the engine handshake and returns data/done.
module line_access_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned LINE_W       = 256,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WbReq,
    input  logic [ADDR_W-1:0] WbAddr,
    input  logic [LINE_W-1:0] WbData,
    output logic              WbDone,
    input  logic              DfReq,
    input  logic [ADDR_W-1:0] DfAddr,
    output logic [LINE_W-1:0] DfData,
    output logic              DfDone,
    input  logic              IfReq,
    input  logic [ADDR_W-1:0] IfAddr,
    output logic [LINE_W-1:0] IfData,
    output logic              IfDone,
    output logic [ADDR_W-1:0] AXIAddr,
    output logic [LINE_W-1:0] AXIData,
    output logic              AXIStartWrite,
    output logic              AXIStartRead,
    input  logic              AXICompleted,
    input  logic [LINE_W-1:0] AXIReadData,
    output logic [1:0]        GrantId,
    output logic              Busy
);
    localparam int unsigned CNT_W    = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned LINE_OFS = 5;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_WB   = 2'd1;
    localparam logic [1:0] GNT_DF   = 2'd2;
    localparam logic [1:0] GNT_IF   = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  starve_cnt, starve_nxt;
    logic [1:0]        grant_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [LINE_W-1:0] wdata_nxt, df_data_nxt, if_data_nxt;
    logic              start_wr_nxt, start_rd_nxt;
    logic              wb_done_nxt, df_done_nxt, if_done_nxt;
    logic              same_line, starved, if_forced;

    // A writeback to the line being fetched must land before the fill, even when If is starved.
    assign same_line = (WbAddr[ADDR_W-1:LINE_OFS] == IfAddr[ADDR_W-1:LINE_OFS]);
    assign starved   = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign if_forced = starved && IfReq && !(WbReq && same_line);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= S_IDLE;
            starve_cnt    <= '0;
            GrantId       <= GNT_NONE;
            AXIAddr       <= '0;
            AXIData       <= '0;
            AXIStartWrite <= 1'b0;
            AXIStartRead  <= 1'b0;
            WbDone        <= 1'b0;
            DfDone        <= 1'b0;
            IfDone        <= 1'b0;
            DfData        <= '0;
            IfData        <= '0;
            Busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            starve_cnt    <= starve_nxt;
            GrantId       <= grant_nxt;
            AXIAddr       <= addr_nxt;
            AXIData       <= wdata_nxt;
            AXIStartWrite <= start_wr_nxt;
            AXIStartRead  <= start_rd_nxt;
            WbDone        <= wb_done_nxt;
            DfDone        <= df_done_nxt;
            IfDone        <= if_done_nxt;
            DfData        <= df_data_nxt;
            IfData        <= if_data_nxt;
            Busy          <= (state_nxt != S_IDLE);
        end
    end

    always_comb begin
        state_nxt    = state;
        starve_nxt   = starve_cnt;
        grant_nxt    = GrantId;
        addr_nxt     = AXIAddr;
        wdata_nxt    = AXIData;
        df_data_nxt  = DfData;
        if_data_nxt  = IfData;
        start_wr_nxt = 1'b0;
        start_rd_nxt = 1'b0;
        wb_done_nxt  = 1'b0;
        df_done_nxt  = 1'b0;
        if_done_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                if (if_forced)  grant_nxt = GNT_IF;
                else if (WbReq) grant_nxt = GNT_WB;
                else if (DfReq) grant_nxt = GNT_DF;
                else if (IfReq) grant_nxt = GNT_IF;
                else            grant_nxt = GNT_NONE;

                if (!IfReq || grant_nxt == GNT_IF) begin
                    starve_nxt = '0;
                end else if (grant_nxt != GNT_NONE && !starved) begin
                    starve_nxt = starve_cnt + CNT_W'(1);
                end

                case (grant_nxt)
                    GNT_WB: begin
                        addr_nxt     = WbAddr;
                        wdata_nxt    = WbData;
                        start_wr_nxt = 1'b1;
                    end
                    GNT_DF: begin
                        addr_nxt     = DfAddr;
                        start_rd_nxt = 1'b1;
                    end
                    GNT_IF: begin
                        addr_nxt     = IfAddr;
                        start_rd_nxt = 1'b1;
                    end
                    default: ;
                endcase

                if (grant_nxt != GNT_NONE) state_nxt = S_START;
            end
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                if (AXICompleted) begin
                    state_nxt = S_RESP;
                    case (GrantId)
                        GNT_WB: wb_done_nxt = 1'b1;
                        GNT_DF: begin
                            df_data_nxt = AXIReadData;
                            df_done_nxt = 1'b1;
                        end
                        GNT_IF: begin
                            if_data_nxt = AXIReadData;
                            if_done_nxt = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
                grant_nxt = GNT_NONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_line_access_arbiter.sv
// Randomized bench for line_access_arbiter against a transaction-level reference model.
module tb_line_access_arbiter;
    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned LINE_W       = 256;
    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned L            = LINE_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_req, df_req, if_req;
    logic [ADDR_W-1:0] wb_addr, df_addr, if_addr;
    logic [LINE_W-1:0] wb_data;
    logic              wb_done, df_done, if_done;
    logic [LINE_W-1:0] df_data, if_data;
    logic [ADDR_W-1:0] axi_addr;
    logic [LINE_W-1:0] axi_data, axi_read_data;
    logic              axi_start_write, axi_start_read, axi_completed;
    logic [1:0]        grant_id;
    logic              busy;

    int                n_checks = 0;
    int                n_pass   = 0;
    int                m_cnt    = 0;
    logic [LINE_W-1:0] m_df_data = '0;
    logic [LINE_W-1:0] m_if_data = '0;
    logic [1:0]        g;

    line_access_arbiter #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .Clk(clk), .Reset(rst),
        .WbReq(wb_req), .WbAddr(wb_addr), .WbData(wb_data), .WbDone(wb_done),
        .DfReq(df_req), .DfAddr(df_addr), .DfData(df_data), .DfDone(df_done),
        .IfReq(if_req), .IfAddr(if_addr), .IfData(if_data), .IfDone(if_done),
        .AXIAddr(axi_addr), .AXIData(axi_data),
        .AXIStartWrite(axi_start_write), .AXIStartRead(axi_start_read),
        .AXICompleted(axi_completed), .AXIReadData(axi_read_data),
        .GrantId(grant_id), .Busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Winner from the arbitration rules: starved If wins unless a same-line writeback is pending.
    function automatic logic [1:0] pick();
        if (m_cnt == STARVE_LIMIT && if_req && !(wb_req && wb_addr[ADDR_W-1:5] == if_addr[ADDR_W-1:5]))
            return 2'd3;
        if (wb_req) return 2'd1;
        if (df_req) return 2'd2;
        if (if_req) return 2'd3;
        return 2'd0;
    endfunction

    task automatic raise_some();
        if (!wb_req && $urandom_range(0, 2) != 0) begin
            wb_addr = $urandom; wb_data = rand_line(); wb_req = 1'b1;
        end
        if (!df_req && $urandom_range(0, 2) != 0) begin
            df_addr = $urandom; df_req = 1'b1;
        end
        if (!if_req && $urandom_range(0, 1) != 0) begin
            if ($urandom_range(0, 3) == 0) if_addr = {wb_addr[ADDR_W-1:5], 5'($urandom_range(0, 31))};
            else                           if_addr = $urandom;
            if_req = 1'b1;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  L'(busy), L'(1'b0));
        check({tag, "_grant"}, L'(grant_id), L'(2'd0));
        check({tag, "_done"},  L'({wb_done, df_done, if_done}), L'(3'd0));
        check({tag, "_start"}, L'({axi_start_write, axi_start_read}), L'(2'd0));
        check({tag, "_dfdata"}, df_data, m_df_data);
        check({tag, "_ifdata"}, if_data, m_if_data);
    endtask

    // One full transfer from an IDLE cycle with at least one request pending.
    task automatic serve(input int delay, input bit churn, output logic [1:0] got_grant);
        logic [1:0]        w;
        logic [ADDR_W-1:0] exp_addr;
        logic [LINE_W-1:0] exp_wdata, rd;
        w         = pick();
        exp_addr  = (w == 2'd1) ? wb_addr : (w == 2'd2) ? df_addr : if_addr;
        exp_wdata = wb_data;
        if (!if_req || w == 2'd3)   m_cnt = 0;
        else if (m_cnt < STARVE_LIMIT) m_cnt++;
        tick;
        got_grant = grant_id;
        check("grant", L'(grant_id), L'(w));
        check("busy_start", L'(busy), L'(1'b1));
        check("start_write", L'(axi_start_write), L'(w == 2'd1));
        check("start_read", L'(axi_start_read), L'(w != 2'd1));
        check("axi_addr", L'(axi_addr), L'(exp_addr));
        if (w == 2'd1) check("axi_data", axi_data, exp_wdata);
        tick;
        check("start_clear", L'({axi_start_write, axi_start_read}), L'(2'd0));
        for (int i = 0; i < delay; i++) begin
            if (churn && $urandom_range(0, 3) == 0) raise_some();
            tick;
            check("wait_done", L'({wb_done, df_done, if_done}), L'(3'd0));
            check("wait_hold", L'({grant_id, axi_addr}), L'({w, exp_addr}));
        end
        rd = rand_line();
        axi_completed = 1'b1; axi_read_data = rd;
        tick;
        axi_completed = 1'b0; axi_read_data = rand_line();
        if (w == 2'd2) m_df_data = rd;
        if (w == 2'd3) m_if_data = rd;
        check("done_pulse", L'({wb_done, df_done, if_done}),
              L'({w == 2'd1, w == 2'd2, w == 2'd3}));
        check("resp_start", L'({axi_start_write, axi_start_read}), L'(2'd0));
        check("df_data", df_data, m_df_data);
        check("if_data", if_data, m_if_data);
        if (w == 2'd1) wb_req = 1'b0;
        if (w == 2'd2) df_req = 1'b0;
        if (w == 2'd3) if_req = 1'b0;
        tick;
        check_idle("post");
    endtask

    initial begin
        rst = 1'b1;
        wb_req = 1'b0; df_req = 1'b0; if_req = 1'b0;
        wb_addr = '0; df_addr = '0; if_addr = '0; wb_data = '0;
        axi_completed = 1'b0; axi_read_data = '0;
        tick; tick;
        check_idle("reset");
        check("reset_axi", L'(axi_addr), L'(0));
        check("reset_axidata", axi_data, '0);
        rst = 1'b0;
        tick;
        check_idle("idle0");

        // single instruction fill
        if_addr = 32'h0000_1040; if_req = 1'b1;
        serve(3, 1'b0, g);
        check("if_single_grant", L'(g), L'(2'd3));

        // simultaneous requests on distinct lines
        wb_addr = 32'h100; wb_data = rand_line(); df_addr = 32'h200; if_addr = 32'h300;
        wb_req = 1'b1; df_req = 1'b1; if_req = 1'b1;
        serve(1, 1'b0, g); check("order_wb", L'(g), L'(2'd1));
        serve(2, 1'b0, g); check("order_df", L'(g), L'(2'd2));
        serve(0, 1'b0, g); check("order_if", L'(g), L'(2'd3));

        // If held while Wb/Df keep re-requesting
        wb_addr = 32'h4000; df_addr = 32'h6000; if_addr = 32'h8000;
        wb_req = 1'b1; df_req = 1'b1; if_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve(1, 1'b0, g);
            check("starve_pre", L'(g == 2'd3), L'(1'b0));
            if (!wb_req) begin wb_data = rand_line(); wb_req = 1'b1; end
            if (!df_req) df_req = 1'b1;
        end
        serve(1, 1'b0, g); check("starve_if", L'(g), L'(2'd3));
        serve(0, 1'b0, g); serve(0, 1'b0, g);

        // starved If on the same line as a pending writeback
        wb_addr = 32'h2000; if_addr = 32'h2010; if_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wb_data = rand_line(); wb_req = 1'b1;
            serve(1, 1'b0, g);
            check("sameline_wb", L'(g), L'(2'd1));
        end
        serve(1, 1'b0, g); check("sameline_if", L'(g), L'(2'd3));

        // reset while a data fill waits on the engine
        df_addr = 32'h0000_7780; df_req = 1'b1;
        tick;
        check("rst_df_grant", L'(grant_id), L'(2'd2));
        tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0; df_req = 1'b0;
        m_cnt = 0; m_df_data = '0; m_if_data = '0;
        check_idle("rst_mid");
        axi_completed = 1'b1; axi_read_data = rand_line();
        tick;
        axi_completed = 1'b0;
        check_idle("rst_late_cpl");
        tick;
        check_idle("rst_after");

        // spurious completion while idle
        axi_completed = 1'b1; axi_read_data = rand_line();
        tick;
        axi_completed = 1'b0;
        check_idle("spurious");

        for (int it = 0; it < 200; it++) begin
            raise_some();
            if (!wb_req && !df_req && !if_req) begin
                if ($urandom_range(0, 1) != 0) begin
                    axi_completed = 1'b1; axi_read_data = rand_line();
                end
                m_cnt = 0;
                tick;
                axi_completed = 1'b0;
                check_idle("rnd_idle");
            end else begin
                serve($urandom_range(0, 6), 1'b1, g);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
